// File: rtl/regfile_seq.sv
// Sequencer that drives a register file and ALU. Each instruction walks a fixed
// Moore state path, and every output is decoded from the registered state and the latched op/rn.
module regfile_seq (
  input  logic       clk,
  input  logic       clr,
  input  logic       instr_valid,
  input  logic [2:0] op,
  input  logic [2:0] rn,
  output logic       instr_ready,
  output logic       rf_clr,
  output logic       rf_we,
  output logic [1:0] rf_mux_sel,
  output logic [2:0] rf_read_seg,
  output logic [2:0] rf_write_seg,
  output logic       alu_en,
  output logic       done,
  output logic       err,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_EXEC  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [2:0] rn_q, rn_d;
  logic       arm_q, arm_d;
  logic [7:0] retired_q, retired_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_INIT;
      op_q      <= 3'b000;
      rn_q      <= 3'b000;
      arm_q     <= 1'b0;
      retired_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rn_q      <= rn_d;
      arm_q     <= arm_d;
      retired_q <= retired_d;
    end
  end

  // arm_q stretches INIT so that rf_clr spans one full clock after reset release.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rn_d      = rn_q;
    arm_d     = arm_q;
    retired_d = retired_q;
    case (state_q)
      S_INIT: begin
        arm_d = 1'b1;
        if (arm_q) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (instr_valid) begin
          op_d = op;
          rn_d = rn;
          case (op)
            3'b001, 3'b010: state_d = (rn == 3'b000) ? S_DONE : S_WRITE;
            3'b011:         state_d = S_WRITE;
            3'b100, 3'b101: state_d = S_READ;
            default:        state_d = S_DONE;
          endcase
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  state_d = S_EXEC;
      S_EXEC:  state_d = (op_q == 3'b100) ? S_WRITE : S_DONE;
      S_WRITE: state_d = S_DONE;
      S_DONE: begin
        state_d   = S_IDLE;
        retired_d = retired_q + 8'd1;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    instr_ready  = 1'b0;
    rf_clr       = 1'b0;
    rf_we        = 1'b0;
    rf_mux_sel   = 2'b00;
    rf_read_seg  = 3'b000;
    rf_write_seg = 3'b000;
    alu_en       = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (state_q)
      S_INIT: rf_clr      = 1'b1;
      S_IDLE: instr_ready = 1'b1;
      S_READ, S_WAIT: rf_read_seg = rn_q;
      S_EXEC: begin
        rf_read_seg = rn_q;
        alu_en      = 1'b1;
      end
      S_WRITE: begin
        rf_we = 1'b1;
        case (op_q)
          3'b001: begin rf_mux_sel = 2'b00; rf_write_seg = rn_q;   end
          3'b010: begin rf_mux_sel = 2'b01; rf_write_seg = rn_q;   end
          3'b011: begin rf_mux_sel = 2'b10; rf_write_seg = rn_q;   end
          3'b100: begin rf_mux_sel = 2'b11; rf_write_seg = 3'b000; end
          default: begin rf_mux_sel = 2'b00; rf_write_seg = 3'b000; end
        endcase
      end
      S_DONE: begin
        done = 1'b1;
        err  = op_q[2] & op_q[1];
      end
      default: ;
    endcase
  end

  assign retired = retired_q;

endmodule
